// File: rtl/rx_escape_pkg.sv
// Shared types for the RX un-escaper: FIFO entry layout, escape FSM states
// and the default escape symbol.
package rx_escape_pkg;

  localparam logic [7:0] ESC_DEFAULT = 8'hB1;

  typedef struct packed {
    logic       cmd;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ESCAPE = 1'b1
  } state_t;

  function automatic rx_entry_t make_entry(input logic cmd, input logic [7:0] data);
    rx_entry_t e;
    e.cmd  = cmd;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/rx_escape_fifo_if.sv
// Bundle of the UART-RX side, TAP side and status signals of rx_escape_fifo.
// The slave modport is the un-escaper itself; master is whoever drives it.
interface rx_escape_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [7:0]    DATA_REC_I;
  logic          RX_EMPTY_I;
  logic          READ_O;
  logic          READ_I;
  logic          RX_EMPTY_O;
  logic          COMMAND_O;
  logic [7:0]    DATA_REC_O;
  logic          FLUSH_I;
  logic          ESC_ERR_O;
  logic [LW-1:0] LEVEL_O;

  modport master (
    output DATA_REC_I, RX_EMPTY_I, READ_I, FLUSH_I,
    input  READ_O, RX_EMPTY_O, COMMAND_O, DATA_REC_O, ESC_ERR_O, LEVEL_O
  );

  modport slave (
    input  DATA_REC_I, RX_EMPTY_I, READ_I, FLUSH_I,
    output READ_O, RX_EMPTY_O, COMMAND_O, DATA_REC_O, ESC_ERR_O, LEVEL_O
  );

endinterface

// File: rtl/rx_fifo_fwft.sv
// First-word-fall-through FIFO with occupancy count and synchronous flush.
// The head entry is read combinationally so a push is visible the next cycle.
module rx_fifo_fwft
  import rx_escape_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = rx_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           wdata_i,
  input  logic                       pop_i,
  output T                           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;

  // A pop in the same cycle makes room, so push-at-full is legal with a pop.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Stale RAM contents stay hidden while the FIFO is empty.
  always_comb begin
    rdata_o = '0;
    if (!empty_o) begin
      rdata_o = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/rx_escape_fifo.sv
// RX un-escaper: drains UART-RX, folds ESC sequences into {cmd,byte} entries
// and buffers them for the TAP, with escape timeout, flush and fill level.
module rx_escape_fifo
  import rx_escape_pkg::*;
#(
  parameter logic [7:0] ESC     = ESC_DEFAULT,
  parameter int         DEPTH   = 8,
  parameter int         TIMEOUT = 0
) (
  input  logic             CLK_I,
  input  logic             RST_NI,
  rx_escape_fifo_if.slave  bus
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          esc_err_q, esc_err_d;

  logic          fifo_full, fifo_empty;
  logic          consume, push;
  rx_entry_t     push_entry, head;
  logic [LW-1:0] level;

  // Fullness comes from the registered count: a same-cycle TAP pop does not
  // open a slot for RX.
  assign consume    = RST_NI && !bus.RX_EMPTY_I && !fifo_full && !bus.FLUSH_I;
  assign bus.READ_O = consume;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    esc_err_d  = 1'b0;
    push       = 1'b0;
    push_entry = make_entry(1'b0, bus.DATA_REC_I);
    if (bus.FLUSH_I) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (consume) begin
            if (bus.DATA_REC_I == ESC) begin
              state_d = ST_ESCAPE;
              timer_d = '0;
            end else begin
              push = 1'b1;
            end
          end
        end
        ST_ESCAPE: begin
          if (consume) begin
            push       = 1'b1;
            push_entry = make_entry(bus.DATA_REC_I != ESC, bus.DATA_REC_I);
            state_d    = ST_IDLE;
          end else if (TIMEOUT != 0 && timer_q == TIMER_LAST) begin
            esc_err_d = 1'b1;
            state_d   = ST_IDLE;
            timer_d   = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      esc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      esc_err_q <= esc_err_d;
    end
  end

  rx_fifo_fwft #(
    .DEPTH (DEPTH),
    .T     (rx_entry_t)
  ) u_fifo (
    .clk_i   (CLK_I),
    .rst_ni  (RST_NI),
    .flush_i (bus.FLUSH_I),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (bus.READ_I),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign bus.RX_EMPTY_O = fifo_empty;
  assign bus.COMMAND_O  = head.cmd;
  assign bus.DATA_REC_O = head.data;
  assign bus.LEVEL_O    = level;
  assign bus.ESC_ERR_O  = esc_err_q;

endmodule

// File: tb/tb_rx_escape_fifo.sv
// Scoreboard bench for rx_escape_fifo: a byte-level un-escape model pushes
// expected entries, a negedge monitor pops and compares the TAP side.
module tb_rx_escape_fifo;
  import rx_escape_pkg::*;

  localparam int         DEPTH   = 4;
  localparam int         TIMEOUT = 16;
  localparam logic [7:0] ESC     = 8'hB1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_escape_fifo_if #(.DEPTH(DEPTH)) bus_if ();

  rx_escape_fifo #(
    .ESC     (ESC),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK_I  (clk),
    .RST_NI (rst_n),
    .bus    (bus_if)
  );

  rx_entry_t  exp_q[$];
  logic [7:0] src_q[$];
  bit         esc_pend;
  int         idle_cnt;
  bit         exp_err;
  bit         fresh;
  int         mon_level = 0;
  int         compared = 0;
  int         mismatched = 0;
  int         err_seen = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    esc_pend = 1'b0;
    idle_cnt = 0;
    exp_err  = 1'b0;
    fresh    = 1'b1;
  endfunction

  function automatic void push_exp(input logic cmd, input logic [7:0] b);
    exp_q.push_back(make_entry(cmd, b));
    fresh = 1'b0;
  endfunction

  // Byte-stream view of one clock edge, using the inputs held during the cycle.
  task automatic model_edge();
    logic [7:0] b;
    if (!rst_n) return;
    if (bus_if.FLUSH_I) begin
      exp_q.delete();
      esc_pend = 1'b0;
      idle_cnt = 0;
      exp_err  = 1'b0;
      return;
    end
    exp_err = 1'b0;
    if (!bus_if.RX_EMPTY_I && mon_level < DEPTH) begin
      b = src_q.pop_front();
      if (!esc_pend) begin
        if (b == ESC) begin
          esc_pend = 1'b1;
          idle_cnt = 0;
        end else begin
          push_exp(1'b0, b);
        end
      end else begin
        push_exp(b != ESC, b);
        esc_pend = 1'b0;
      end
    end else if (esc_pend) begin
      idle_cnt++;
      if (idle_cnt == TIMEOUT) begin
        esc_pend = 1'b0;
        exp_err  = 1'b1;
      end
    end
  endtask

  task automatic drive(input int rx_pct, input int tap_pct, input bit fl);
    bus_if.FLUSH_I = fl;
    bus_if.READ_I  = ($urandom_range(99) < tap_pct);
    if (src_q.size() > 0 && $urandom_range(99) < rx_pct) begin
      bus_if.RX_EMPTY_I = 1'b0;
      bus_if.DATA_REC_I = src_q[0];
    end else begin
      bus_if.RX_EMPTY_I = 1'b1;
      bus_if.DATA_REC_I = 8'($urandom);
    end
  endtask

  task automatic step(input int rx_pct, input int tap_pct, input bit fl);
    @(posedge clk);
    model_edge();
    #1;
    drive(rx_pct, tap_pct, fl);
  endtask

  task automatic run(input int n, input int rx_pct, input int tap_pct);
    for (int i = 0; i < n; i++) step(rx_pct, tap_pct, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() > 0 || src_q.size() > 0 || esc_pend) && guard < 200) begin
      step(100, 100, 1'b0);
      guard++;
    end
    check("drain_bounded", 32'(guard < 200), 32'(1));
    step(0, 0, 1'b0);
  endtask

  // RX keeps offering data while reset is low; nothing may be consumed.
  task automatic pulse_reset();
    @(posedge clk);
    model_edge();
    #1;
    rst_n = 1'b0;
    model_clear();
    drive(100, 100, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_head_now(input string name, input logic [8:0] req);
    @(negedge clk);
    #1;
    check(name, 32'({bus_if.COMMAND_O, bus_if.DATA_REC_O}), 32'(req));
  endtask

  always @(negedge clk) begin
    int sz;
    sz = exp_q.size();
    check("read_o", 32'(bus_if.READ_O),
          32'(rst_n && !bus_if.RX_EMPTY_I && sz < DEPTH && !bus_if.FLUSH_I));
    check("rx_empty_o", 32'(bus_if.RX_EMPTY_O), 32'(sz == 0));
    check("level_o", 32'(bus_if.LEVEL_O), 32'(sz));
    check("esc_err_o", 32'(bus_if.ESC_ERR_O), 32'(exp_err));
    if (bus_if.ESC_ERR_O) err_seen++;
    if (sz > 0) begin
      check("head", 32'({bus_if.COMMAND_O, bus_if.DATA_REC_O}), 32'(exp_q[0]));
    end else if (fresh) begin
      check("head_after_reset", 32'({bus_if.COMMAND_O, bus_if.DATA_REC_O}), 32'(0));
    end
    mon_level = sz;
    if (rst_n && bus_if.READ_I && !bus_if.FLUSH_I && sz > 0) begin
      void'(exp_q.pop_front());
      $display("pop  cmd=%0d data=0x%02h level_before=%0d", bus_if.COMMAND_O, bus_if.DATA_REC_O, sz);
    end
  end

  initial begin
    int e0;
    int r;
    bus_if.DATA_REC_I = 8'h00;
    bus_if.RX_EMPTY_I = 1'b1;
    bus_if.READ_I     = 1'b0;
    bus_if.FLUSH_I    = 1'b0;
    model_clear();
    src_q.push_back(8'h77);
    drive(100, 100, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_q.delete();
    drive(0, 0, 1'b0);

    // Plain bytes
    src_q.push_back(8'h12);
    src_q.push_back(8'h34);
    run(4, 100, 0);
    @(negedge clk);
    #1;
    check("t1_level", 32'(bus_if.LEVEL_O), 32'(2));
    check_head_now("t1_head", 9'h012);
    drain();

    // ESC ESC -> literal ESC
    src_q.push_back(ESC);
    src_q.push_back(ESC);
    run(4, 100, 0);
    @(negedge clk);
    #1;
    check("t2_level", 32'(bus_if.LEVEL_O), 32'(1));
    check_head_now("t2_head", {1'b0, ESC});
    drain();

    // ESC x -> command
    src_q.push_back(ESC);
    src_q.push_back(8'h05);
    run(4, 100, 0);
    check_head_now("t3_head", 9'h105);
    drain();

    // Back-pressure with a stalled TAP
    for (int i = 1; i <= 6; i++) src_q.push_back(8'(i));
    run(8, 100, 0);
    @(negedge clk);
    #1;
    check("t4_level_full", 32'(bus_if.LEVEL_O), 32'(DEPTH));
    check("t4_read_low", 32'(bus_if.READ_O), 32'(0));
    step(100, 100, 1'b0);
    step(100, 0, 1'b0);
    step(100, 0, 1'b0);
    step(100, 0, 1'b0);
    @(negedge clk);
    #1;
    check("t4_level_refull", 32'(bus_if.LEVEL_O), 32'(DEPTH));
    check_head_now("t4_head", 9'h002);
    drain();

    // Escape timeout
    e0 = err_seen;
    src_q.push_back(ESC);
    run(2, 100, 0);
    run(22, 0, 0);
    check("t5_err_pulses", 32'(err_seen - e0), 32'(1));
    check("t5_empty", 32'(bus_if.RX_EMPTY_O), 32'(1));
    src_q.push_back(8'h05);
    run(3, 100, 0);
    check_head_now("t5_head", 9'h005);
    drain();

    // Flush drops a pending escape silently
    e0 = err_seen;
    src_q.push_back(ESC);
    run(3, 100, 0);
    step(0, 0, 1'b1);
    step(0, 0, 1'b0);
    @(negedge clk);
    #1;
    check("t6_flush_empty", 32'(bus_if.RX_EMPTY_O), 32'(1));
    src_q.push_back(8'h05);
    run(3, 100, 0);
    check_head_now("t6_head", 9'h005);
    drain();

    // Reset drops a pending escape too
    src_q.push_back(ESC);
    run(3, 100, 0);
    pulse_reset();
    src_q.push_back(8'h05);
    run(3, 100, 0);
    check_head_now("t6r_head", 9'h005);
    check("t6_no_err", 32'(err_seen - e0), 32'(0));
    drain();

    // Randomized traffic with occasional flushes and resets
    for (int blk = 0; blk < 40; blk++) begin
      int rxp;
      int tpp;
      rxp = $urandom_range(100);
      tpp = $urandom_range(100);
      $display("block %0d rx_pct=%0d tap_pct=%0d", blk, rxp, tpp);
      for (int i = 0; i < 60; i++) begin
        if (src_q.size() < 8) begin
          src_q.push_back(($urandom_range(99) < 30) ? ESC : 8'($urandom));
        end
        r = $urandom_range(999);
        if (r < 8) step(rxp, tpp, 1'b1);
        else if (r < 10) pulse_reset();
        else step(rxp, tpp, 1'b0);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
